seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_tick_gen.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the segment scan controller.
// Pure definitions: no latency, no flow control.
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  typedef struct packed {
    logic [8*NUM_DIGITS-1:0] seg;
    logic [NUM_DIGITS-1:0]   dot;
  } frame_t;

  // Active-low pattern for one digit; a requested DP pulls bit 7 low.
  function automatic logic [7:0] digit_pattern(input frame_t f, input logic [2:0] idx);
    logic [7:0] p;
    p = f.seg[{idx, 3'b000} +: 8];
    if (f.dot[idx]) p[7] = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Dwell/gap down-counter; tc is high while the count sits at zero.
// Latency: load takes effect on the next edge. Backpressure: none.
module seg_tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-segment scanner with double-buffered frame updates.
// Latency: update in IDLE shows next cycle; later updates land at the next frame start.
// Backpressure: upd_ready=0 while a shadow update is pending. Option: SEG_SCAN_BRIGHT_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [63:0] seg_data,
  input  logic [7:0]  dot_disp,
  input  logic [7:0]  digit_en,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [2:0]  bright,
`endif
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);

  localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(BLANK_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  frame_t     active_q, active_d;
  frame_t     shadow_q, shadow_d;
  logic       pending_q, pending_d;

  logic             tick_load;
  logic [CNT_W-1:0] tick_val;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_tc;
  logic             upd_fire;

  logic [2:0]  bright_lvl;
  logic [31:0] dwell_elapsed, dwell_on;
  logic        drive_on;

  seg_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tick_load),
    .load_val (tick_val),
    .cnt      (tick_cnt),
    .tc       (tick_tc)
  );

`ifdef SEG_SCAN_BRIGHT_EN
  assign bright_lvl = bright;
`else
  assign bright_lvl = 3'd7;
`endif

  // Level 7 yields an on-window equal to the full dwell.
  always_comb begin
    dwell_elapsed = 32'(CLK_DIV - 1) - 32'(tick_cnt);
    dwell_on      = ((32'(bright_lvl) + 32'd1) * 32'(CLK_DIV)) >> 3;
    drive_on      = (dwell_elapsed < dwell_on);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    tick_load  = 1'b0;
    tick_val   = SHOW_LOAD;
    frame_done = 1'b0;
    upd_ready  = !pending_q;
    upd_fire   = upd_valid && !pending_q;

    case (state_q)
      IDLE: begin
        if (upd_fire) begin
          active_d  = '{seg: seg_data, dot: dot_disp};
          state_d   = SHOW;
          idx_d     = 3'd0;
          tick_load = 1'b1;
          tick_val  = SHOW_LOAD;
        end
      end
      SHOW: begin
        if (upd_fire) begin
          shadow_d  = '{seg: seg_data, dot: dot_disp};
          pending_d = 1'b1;
        end
        if (tick_tc) begin
          state_d   = GAP;
          tick_load = 1'b1;
          tick_val  = GAP_LOAD;
        end
      end
      GAP: begin
        if (upd_fire) begin
          shadow_d  = '{seg: seg_data, dot: dot_disp};
          pending_d = 1'b1;
        end
        if (tick_tc) begin
          state_d   = SHOW;
          idx_d     = idx_q + 3'd1;
          tick_load = 1'b1;
          tick_val  = SHOW_LOAD;
          // Swap only at frame end so a frame never mixes old and new data.
          if (idx_q == 3'd7) begin
            frame_done = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    an_out  = AN_OFF;
    seg_out = SEG_BLANK;
    if (state_q == SHOW && digit_en[idx_q] && drive_on) begin
      an_out  = ~(8'd1 << idx_q);
      seg_out = digit_pattern(active_q, idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      active_q  <= '1;
      shadow_q  <= '1;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at CLK_DIV=4, BLANK_CYCLES=1 (40-cycle frames).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [63:0] seg_data;
  logic [7:0]  dot_disp;
  logic [7:0]  digit_en;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        frame_done;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [2:0]  bright;
`endif

  int checks;
  int failures;

  // Digit 0 = C0, digit 1 = F9, ... digit 7 = F8.
  localparam logic [63:0] PAT_A = 64'hF8829299B0A4F9C0;
  localparam logic [63:0] PAT_B = 64'h8877665544332211;
  localparam logic [63:0] PAT_C = 64'h0807060504030201;
  logic [7:0] pat_a_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .seg_data   (seg_data),
    .dot_disp   (dot_disp),
    .digit_en   (digit_en),
`ifdef SEG_SCAN_BRIGHT_EN
    .bright     (bright),
`endif
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    upd_valid = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask

  // Leaves the bench at cycle k=0 of the first frame (digit 0 just entered).
  task automatic start_frame(input logic [63:0] d, input logic [7:0] dot, input logic [7:0] en);
    do_reset();
    tick();
    seg_data  = d;
    dot_disp  = dot;
    digit_en  = en;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_valid = 1'b0; seg_data = '0; dot_disp = '0; digit_en = 8'hFF;
    #3;
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL reset_an an_out=%h exp=ff", an_out); end
    checks++; if (seg_out !== 8'hFF) begin failures++; $display("FAIL reset_seg seg_out=%h exp=ff", seg_out); end
    checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL reset_rdy upd_ready=%b exp=1", upd_ready); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd frame_done=%b exp=0", frame_done); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL idle_an an_out=%h exp=ff", an_out); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_an, exp_seg;
    logic       exp_fd;
    int         slot, pos;
    start_frame(PAT_A, 8'h00, 8'hFF);
    for (int k = 0; k < 80; k++) begin
      slot    = (k % 40) / 5;
      pos     = k % 5;
      exp_an  = (pos < 4) ? ~(8'd1 << slot) : 8'hFF;
      exp_seg = (pos < 4) ? pat_a_tab[slot] : 8'hFF;
      exp_fd  = ((k % 40) == 39);
      checks++; if (an_out !== exp_an) begin failures++; $display("FAIL scan_an k=%0d an_out=%h exp=%h", k, an_out, exp_an); end
      checks++; if (seg_out !== exp_seg) begin failures++; $display("FAIL scan_seg k=%0d seg_out=%h exp=%h", k, seg_out, exp_seg); end
      checks++; if (frame_done !== exp_fd) begin failures++; $display("FAIL scan_fd k=%0d frame_done=%b exp=%b", k, frame_done, exp_fd); end
      tick();
    end
  endtask

  task automatic test_dot();
    start_frame(PAT_A, 8'h01, 8'hFF);
    checks++; if (seg_out !== 8'h40) begin failures++; $display("FAIL dot_d0 seg_out=%h exp=40", seg_out); end
    tick();
    dot_disp = 8'h00;
    repeat (4) tick();
    checks++; if (seg_out !== 8'hF9) begin failures++; $display("FAIL dot_d1 seg_out=%h exp=f9", seg_out); end
    checks++; if (an_out !== 8'hFD) begin failures++; $display("FAIL dot_an1 an_out=%h exp=fd", an_out); end
    repeat (35) tick();
    checks++; if (seg_out !== 8'h40) begin failures++; $display("FAIL dot_latched seg_out=%h exp=40", seg_out); end
  endtask

  task automatic test_update_midframe();
    start_frame(PAT_A, 8'h00, 8'hFF);
    repeat (10) tick();
    checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL upd_rdy10 upd_ready=%b exp=1", upd_ready); end
    seg_data = PAT_B; upd_valid = 1'b1;
    tick();
    checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL upd_rdy11 upd_ready=%b exp=0", upd_ready); end
    seg_data = PAT_C;
    repeat (4) tick();
    checks++; if (seg_out !== 8'hB0) begin failures++; $display("FAIL upd_notear seg_out=%h exp=b0", seg_out); end
    repeat (24) tick();
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL upd_fd39 frame_done=%b exp=1", frame_done); end
    checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL upd_rdy39 upd_ready=%b exp=0", upd_ready); end
    tick();
    checks++; if (seg_out !== 8'h11) begin failures++; $display("FAIL upd_newd0 seg_out=%h exp=11", seg_out); end
    checks++; if (an_out !== 8'hFE) begin failures++; $display("FAIL upd_an40 an_out=%h exp=fe", an_out); end
    checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL upd_rdy40 upd_ready=%b exp=1", upd_ready); end
    tick();
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL upd_rdy41 upd_ready=%b exp=0", upd_ready); end
    repeat (4) tick();
    checks++; if (seg_out !== 8'h22) begin failures++; $display("FAIL upd_newd1 seg_out=%h exp=22", seg_out); end
    repeat (35) tick();
    checks++; if (seg_out !== 8'h01) begin failures++; $display("FAIL upd_held seg_out=%h exp=01", seg_out); end
    checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL upd_rdy80 upd_ready=%b exp=1", upd_ready); end
  endtask

  task automatic test_digit_en();
    start_frame(PAT_A, 8'h00, 8'h7F);
    repeat (30) tick();
    checks++; if (an_out !== 8'hBF) begin failures++; $display("FAIL en_an6 an_out=%h exp=bf", an_out); end
    checks++; if (seg_out !== 8'h82) begin failures++; $display("FAIL en_seg6 seg_out=%h exp=82", seg_out); end
    repeat (5) tick();
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL en_an7a an_out=%h exp=ff", an_out); end
    checks++; if (seg_out !== 8'hFF) begin failures++; $display("FAIL en_seg7 seg_out=%h exp=ff", seg_out); end
    repeat (3) tick();
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL en_an7b an_out=%h exp=ff", an_out); end
    tick();
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL en_fd39 frame_done=%b exp=1", frame_done); end
    tick();
    checks++; if (an_out !== 8'hFE) begin failures++; $display("FAIL en_an40 an_out=%h exp=fe", an_out); end
    digit_en = 8'hFF;
  endtask

  task automatic test_reset_mid();
    start_frame(PAT_A, 8'h00, 8'hFF);
    repeat (16) tick();
    checks++; if (an_out !== 8'hF7) begin failures++; $display("FAIL rm_pre an_out=%h exp=f7", an_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL rm_an an_out=%h exp=ff", an_out); end
    checks++; if (seg_out !== 8'hFF) begin failures++; $display("FAIL rm_seg seg_out=%h exp=ff", seg_out); end
    checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL rm_rdy upd_ready=%b exp=1", upd_ready); end
    #1 rst_n = 1'b1;
    repeat (45) tick();
    checks++; if (an_out !== 8'hFF) begin failures++; $display("FAIL rm_idle an_out=%h exp=ff", an_out); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rm_fd frame_done=%b exp=0", frame_done); end
    seg_data = PAT_B; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    checks++; if (an_out !== 8'hFE) begin failures++; $display("FAIL rm_restart_an an_out=%h exp=fe", an_out); end
    checks++; if (seg_out !== 8'h11) begin failures++; $display("FAIL rm_restart_seg seg_out=%h exp=11", seg_out); end
  endtask

`ifdef SEG_SCAN_BRIGHT_EN
  task automatic test_bright();
    logic [7:0] exp_an [6] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
    bright = 3'd3;
    start_frame(PAT_A, 8'h00, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      checks++; if (an_out !== exp_an[k]) begin failures++; $display("FAIL bright_an k=%0d an_out=%h exp=%h", k, an_out, exp_an[k]); end
      tick();
    end
    repeat (33) tick();
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL bright_fd frame_done=%b exp=1", frame_done); end
    bright = 3'd7;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
`ifdef SEG_SCAN_BRIGHT_EN
    bright = 3'd7;
`endif
    test_reset();
    test_scan();
    test_dot();
    test_update_midframe();
    test_digit_en();
    test_reset_mid();
`ifdef SEG_SCAN_BRIGHT_EN
    test_bright();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
